hsk_protocol_checker: RTL and testbench
=======================================

HSK_PROTOCOL_CHECKER -- requirements
Module: hsk_protocol_checker

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4: number of independent req/ack channels (>=1).
REQ-002 SHALL provide parameter MIN_LAT, default 1: earliest legal ack edge after req (>=1).
REQ-003 SHALL provide parameter MAX_LAT, default 8: latest legal ack edge after req (>=MIN_LAT).
REQ-004 SHALL provide parameter CNT_W, default 16: width of the saturating counters.
REQ-005 SHALL have the port `clk`, input, 1 bit: sole clock; all logic samples on its rising edge.
REQ-006 SHALL have the port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have the port `clr`, input, 1 bit: synchronous clear of sticky flags and counters.
REQ-008 SHALL have the port `req`, input, NUM_CH bits: per-channel request.
REQ-009 SHALL have the port `ack`, input, NUM_CH bits: per-channel acknowledge.
REQ-010 SHALL have the ports `err_timeout`, `err_early`, `err_drop` and `err_spurious`, each an output of NUM_CH bits: sticky per-channel error flags.
REQ-011 SHALL have the port `err_any`, output, 1 bit: registered OR of all sticky flags.
REQ-012 SHALL have the port `err_cnt`, output, CNT_W bits: saturating count of error events.
REQ-013 SHALL have the port `first_err_valid`, output, 1 bit: qualifies `first_err_ch`.
REQ-014 SHALL have the port `first_err_ch`, output, max(1,$clog2(NUM_CH)) bits: channel of the first error.
REQ-015 SHALL have the port `pass_cnt`, output, CNT_W bits: saturating count of legal handshakes.

Function
REQ-016 Each channel SHALL run an FSM with the states IDLE, WAIT, HOLD, REL and ERR.
REQ-017 Edge 0 SHALL be the edge at which the FSM is in IDLE and samples req=1 with ack=0; the FSM SHALL go to WAIT and its latency counter SHALL be 1 at edge 1.
REQ-018 WAIT, at edge k, ack=1 with MIN_LAT<=k<=MAX_LAT: the handshake SHALL pass and the FSM SHALL go to HOLD.
REQ-019 WAIT, at edge k, ack=1 with k<MIN_LAT: err_early SHALL be flagged and the FSM SHALL go to ERR.
REQ-020 WAIT, at edge k=MAX_LAT, ack=0 and req=1: err_timeout SHALL be flagged and the FSM SHALL go to ERR.
REQ-021 WAIT, req=0 and ack=0: err_drop SHALL be flagged and the FSM SHALL go to IDLE.
REQ-022 When req=0 and ack=1 on the same edge in WAIT, ack SHALL take precedence and the edge SHALL be evaluated under REQ-018/019.
REQ-023 HOLD: req=0 SHALL move the FSM to REL; ack dropping while req=1 SHALL be ignored.
REQ-024 REL: ack=0 SHALL move the FSM to IDLE; req is ignored in REL.
REQ-025 IDLE with ack=1 SHALL flag err_spurious and SHALL go to ERR if req=1, otherwise stay in IDLE.
REQ-026 ERR SHALL exit to IDLE only when req=0 and ack=0 are sampled together.
REQ-027 Each flag SHALL set on the edge that samples the violation and be visible immediately after that edge, with zero added latency.
REQ-028 err_cnt SHALL add the number of error events on each edge (events across all channels) and saturate at 2^CNT_W-1.
REQ-029 On the first error edge after reset or clr, first_err_ch SHALL capture the lowest-indexed erroring channel and first_err_valid SHALL be set to 1.
REQ-030 first_err_ch and first_err_valid SHALL then hold until the next reset or clr.
REQ-031 clr SHALL zero all sticky flags, err_any, the counters and the first_err outputs.
REQ-032 clr SHALL take priority over events on the same edge, which are discarded; clr SHALL NOT alter FSM state.

Reset
REQ-033 While rst_n=0, every output SHALL be 0, every FSM SHALL be in IDLE and every latency counter SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction without flagging an error.
REQ-035 After rst_n release, a req already held high SHALL be treated as a new edge 0.

Configuration
REQ-036 With HSK_CHK_PASS_CNT_EN defined, pass_cnt SHALL count handshakes passing REQ-018 across all channels, saturating and cleared by clr.
REQ-037 Without HSK_CHK_PASS_CNT_EN, pass_cnt SHALL be tied to 0 with no counter logic.

Structure
REQ-038 The package hsk_chk_pkg SHALL hold the FSM state enum and the error-type bit-index constants.
REQ-039 The sub-module hsk_chk_channel (FSM, latency counter, per-edge event pulses) SHALL be instantiated NUM_CH times by generate.
REQ-040 The top level SHALL hold sticky flags, event popcount, counters and first-error capture.

Verification (NUM_CH=4, MIN_LAT=2, MAX_LAT=5, CNT_W=4, macro defined)
REQ-041 ch0: req edge 0, ack edges 3-6, req low edge 5, ack low edge 7 -> no flags, pass_cnt=1, FSM IDLE.
REQ-042 ch1: req held, ack never -> err_timeout[1]=1 after edge 5, err_cnt=1, first_err_valid=1, first_err_ch=1.
REQ-043 ch2 ack at edge 1 -> err_early[2]; ch3 req low at edge 2, no ack -> err_drop[3]; err_any=1.
REQ-044 ch0 spurious ack and ch2 timeout on the same edge from reset -> err_cnt=2, first_err_ch=0; then 20 further spurious events -> err_cnt=15.
REQ-045 rst_n low at edge 3 of a ch0 WAIT -> all outputs 0; req held through release -> new WAIT, pass on ack 2 edges later.
REQ-046 clr on the same edge as a ch1 timeout -> err_timeout[1]=0, err_cnt=0, first_err_valid=0.

Source files
------------

// File: rtl/hsk_chk_pkg.sv
// hsk_chk_pkg: shared FSM states and error-type bit indices for the handshake checker.
package hsk_chk_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_REL, S_ERR} state_t;
  localparam int E_TIMEOUT = 0;
  localparam int E_EARLY = 1;
  localparam int E_DROP = 2;
  localparam int E_SPUR = 3;
  localparam int ERR_W = 4;
endpackage

// File: rtl/hsk_chk_channel.sv
// hsk_chk_channel: one req/ack channel FSM with latency counter and per-edge event pulses.
// HSK_CHK_PASS_CNT_EN adds the pass pulse output.
module hsk_chk_channel
  import hsk_chk_pkg::*;
#(
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             ack,
`ifdef HSK_CHK_PASS_CNT_EN
  output logic             pass,
`endif
  output logic [ERR_W-1:0] ev
);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam logic [LW-1:0] MIN_L = LW'(MIN_LAT);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LAT);
  state_t state, state_nx;
  logic [LW-1:0] lat, lat_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      lat <= '0;
    end else begin
      state <= state_nx;
      lat <= lat_nx;
    end
  // lat holds k, the edge index of the WAIT edge being sampled
  always_comb begin
    state_nx = state;
    lat_nx = '0;
    ev = '0;
`ifdef HSK_CHK_PASS_CNT_EN
    pass = 1'b0;
`endif
    case (state)
      S_IDLE:
        if (ack) begin
          ev[E_SPUR] = 1'b1;
          state_nx = req ? S_ERR : S_IDLE;
        end else if (req) begin
          state_nx = S_WAIT;
          lat_nx = LW'(1);
        end
      S_WAIT:
        if (ack) begin
          ev[E_EARLY] = lat < MIN_L;
          state_nx = lat < MIN_L ? S_ERR : S_HOLD;
`ifdef HSK_CHK_PASS_CNT_EN
          pass = lat >= MIN_L;
`endif
        end else if (!req) begin
          ev[E_DROP] = 1'b1;
          state_nx = S_IDLE;
        end else if (lat == MAX_L) begin
          ev[E_TIMEOUT] = 1'b1;
          state_nx = S_ERR;
        end else
          lat_nx = lat + 1'b1;
      S_HOLD: state_nx = req ? S_HOLD : S_REL;
      S_REL: state_nx = ack ? S_REL : S_IDLE;
      S_ERR: state_nx = (req || ack) ? S_ERR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: rtl/hsk_protocol_checker.sv
// hsk_protocol_checker: multi-channel req/ack protocol checker with sticky flags and counters.
// HSK_CHK_PASS_CNT_EN enables the legal-handshake counter; otherwise pass_cnt is tied to 0.
module hsk_protocol_checker
  import hsk_chk_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 8,
  parameter int CNT_W = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] err_timeout,
  output logic [NUM_CH-1:0] err_early,
  output logic [NUM_CH-1:0] err_drop,
  output logic [NUM_CH-1:0] err_spurious,
  output logic              err_any,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [CH_W-1:0]   first_err_ch,
  output logic [CNT_W-1:0]  pass_cnt
);
  localparam int SW = CNT_W + $clog2(4 * NUM_CH + 1);
  logic [ERR_W-1:0] ev [NUM_CH];
  logic [NUM_CH-1:0] ev_to, ev_early, ev_drop, ev_spur;
  logic [SW-1:0] err_sum;
  logic [CNT_W-1:0] err_cnt_nx;
  logic [CH_W-1:0] first_ch;
  logic hit;
`ifdef HSK_CHK_PASS_CNT_EN
  localparam int PW = CNT_W + $clog2(NUM_CH + 1);
  logic [NUM_CH-1:0] pass;
  logic [PW-1:0] pass_sum;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hsk_chk_channel #(.MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .req(req[i]),
      .ack(ack[i]),
`ifdef HSK_CHK_PASS_CNT_EN
      .pass(pass[i]),
`endif
      .ev(ev[i])
    );
  end
  // Scanning downward leaves first_ch at the lowest-indexed erroring channel
  always_comb begin
    err_sum = {{(SW - CNT_W){1'b0}}, err_cnt};
    first_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      ev_to[c] = ev[c][E_TIMEOUT];
      ev_early[c] = ev[c][E_EARLY];
      ev_drop[c] = ev[c][E_DROP];
      ev_spur[c] = ev[c][E_SPUR];
      err_sum = err_sum + SW'($countones(ev[c]));
      if (|ev[c]) first_ch = CH_W'(c);
    end
    hit = |{ev_to, ev_early, ev_drop, ev_spur};
    err_cnt_nx = |err_sum[SW-1:CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clr) begin
      err_timeout <= '0;
      err_early <= '0;
      err_drop <= '0;
      err_spurious <= '0;
      err_any <= 1'b0;
      err_cnt <= '0;
      first_err_valid <= 1'b0;
      first_err_ch <= '0;
    end else begin
      err_timeout <= err_timeout | ev_to;
      err_early <= err_early | ev_early;
      err_drop <= err_drop | ev_drop;
      err_spurious <= err_spurious | ev_spur;
      err_any <= err_any | hit;
      err_cnt <= err_cnt_nx;
      if (hit && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_ch <= first_ch;
      end
    end
`ifdef HSK_CHK_PASS_CNT_EN
  assign pass_sum = {{(PW - CNT_W){1'b0}}, pass_cnt} + PW'($countones(pass));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clr) pass_cnt <= '0;
    else pass_cnt <= |pass_sum[PW-1:CNT_W] ? '1 : pass_sum[CNT_W-1:0];
`else
  assign pass_cnt = '0;
`endif
endmodule

// File: tb/tb_hsk_protocol_checker.sv
// tb_hsk_protocol_checker: directed bench with an edge-indexed protocol model and literal pins.
module tb_hsk_protocol_checker;
  import hsk_chk_pkg::*;
  localparam int MIN = 2, MAX = 5, SAT = 15;
`ifdef HSK_CHK_PASS_CNT_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_WAIT = 1, P_HOLD = 2, P_REL = 3, P_ERR = 4;
  logic clk = 1'b0, rst_n, clr;
  logic [3:0] req, ack;
  logic [3:0] err_timeout, err_early, err_drop, err_spurious;
  logic err_any, first_err_valid;
  logic [3:0] err_cnt, pass_cnt;
  logic [1:0] first_err_ch;
  int checks = 0, failures = 0;
  bit run = 1'b0;
  hsk_protocol_checker #(.NUM_CH(4), .MIN_LAT(MIN), .MAX_LAT(MAX), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .ack(ack),
    .err_timeout(err_timeout), .err_early(err_early), .err_drop(err_drop),
    .err_spurious(err_spurious), .err_any(err_any), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_ch(first_err_ch), .pass_cnt(pass_cnt)
  );
  always #5 clk = ~clk;
  // Model: each channel remembers its phase and the edge number at which its request started
  int n, ph [4], start [4], m_cnt, m_pass, m_fch, nev, np, lat, low;
  bit [3:0] m_to, m_ea, m_dr, m_sp, e_to, e_ea, e_dr, e_sp;
  bit m_fv, m_any;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_cnt = 0; m_pass = 0; m_fch = 0; m_fv = 0; m_any = 0;
      m_to = '0; m_ea = '0; m_dr = '0; m_sp = '0;
      for (int c = 0; c < 4; c++) begin ph[c] = P_IDLE; start[c] = 0; end
    end else begin
      e_to = '0; e_ea = '0; e_dr = '0; e_sp = '0; np = 0;
      n++;
      for (int c = 0; c < 4; c++) begin
        lat = n - start[c];
        case (ph[c])
          P_IDLE:
            if (ack[c]) begin e_sp[c] = 1; ph[c] = req[c] ? P_ERR : P_IDLE; end
            else if (req[c]) begin ph[c] = P_WAIT; start[c] = n; end
          P_WAIT:
            if (ack[c]) begin
              if (lat < MIN) begin e_ea[c] = 1; ph[c] = P_ERR; end
              else begin np++; ph[c] = P_HOLD; end
            end else if (!req[c]) begin e_dr[c] = 1; ph[c] = P_IDLE; end
            else if (lat == MAX) begin e_to[c] = 1; ph[c] = P_ERR; end
          P_HOLD: if (!req[c]) ph[c] = P_REL;
          P_REL: if (!ack[c]) ph[c] = P_IDLE;
          default: if (!req[c] && !ack[c]) ph[c] = P_IDLE;
        endcase
      end
      nev = $countones({e_to, e_ea, e_dr, e_sp});
      low = 0;
      for (int c = 3; c >= 0; c--) if ({e_to[c], e_ea[c], e_dr[c], e_sp[c]} != 0) low = c;
      if (clr) begin
        m_cnt = 0; m_pass = 0; m_fch = 0; m_fv = 0; m_any = 0;
        m_to = '0; m_ea = '0; m_dr = '0; m_sp = '0;
      end else begin
        m_to |= e_to; m_ea |= e_ea; m_dr |= e_dr; m_sp |= e_sp;
        m_any = m_any || nev > 0;
        m_cnt = m_cnt + nev > SAT ? SAT : m_cnt + nev;
        m_pass = m_pass + np > SAT ? SAT : m_pass + np;
        if (!m_fv && nev > 0) begin m_fv = 1; m_fch = low; end
      end
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (run) begin
    check("err_timeout", 32'(err_timeout), 32'(m_to));
    check("err_early", 32'(err_early), 32'(m_ea));
    check("err_drop", 32'(err_drop), 32'(m_dr));
    check("err_spurious", 32'(err_spurious), 32'(m_sp));
    check("err_any", 32'(err_any), 32'(m_any));
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    check("first_err_valid", 32'(first_err_valid), 32'(m_fv));
    check("first_err_ch", 32'(first_err_ch), m_fv ? 32'(m_fch) : 32'd0);
    check("pass_cnt", 32'(pass_cnt), PEN ? 32'(m_pass) : 32'd0);
  end
  task automatic drive(input logic [3:0] r, input logic [3:0] a);
    req = r;
    ack = a;
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0;
    drive(4'b0, 4'b0);
    drive(4'b0, 4'b0);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; clr = 1'b0; req = '0; ack = '0;
    run = 1'b1;
    do_reset();
    check("reset_outputs", 32'({err_timeout, err_early, err_drop, err_spurious, err_any, err_cnt,
                                first_err_valid, first_err_ch, pass_cnt}), 32'd0);
    // ch0 legal handshake, ack first seen at edge 3
    for (int e = 0; e < 9; e++) drive({3'b0, e < 5}, {3'b0, e >= 3 && e <= 6});
    check("a_flags", 32'({err_timeout, err_early, err_drop, err_spurious, err_any}), 32'd0);
    check("a_pass_cnt", 32'(pass_cnt), PEN ? 32'd1 : 32'd0);
    check("a_ch0_idle", 32'(dut.g_ch[0].u_ch.state), 32'(S_IDLE));
    // ch1 timeout
    do_reset();
    for (int e = 0; e < 6; e++) drive(4'b0010, 4'b0);
    check("b_timeout", 32'(err_timeout), 32'h2);
    check("b_err_cnt", 32'(err_cnt), 32'd1);
    check("b_first_valid", 32'(first_err_valid), 32'd1);
    check("b_first_ch", 32'(first_err_ch), 32'd1);
    for (int e = 0; e < 3; e++) drive(4'b0010, 4'b0);
    check("b_err_cnt_hold", 32'(err_cnt), 32'd1);
    drive(4'b0, 4'b0);
    // ch2 early, ch3 drop
    do_reset();
    drive(4'b1100, 4'b0000);
    drive(4'b1100, 4'b0100);
    drive(4'b0000, 4'b0000);
    check("c_early", 32'(err_early), 32'h4);
    check("c_drop", 32'(err_drop), 32'h8);
    check("c_err_any", 32'(err_any), 32'd1);
    check("c_err_cnt", 32'(err_cnt), 32'd2);
    check("c_first_ch", 32'(first_err_ch), 32'd2);
    // ch0 spurious with ch2 timeout on the same edge, then saturation
    do_reset();
    for (int e = 0; e < 5; e++) drive(4'b0100, 4'b0);
    drive(4'b0100, 4'b0001);
    check("d_err_cnt", 32'(err_cnt), 32'd2);
    check("d_first_ch", 32'(first_err_ch), 32'd0);
    for (int e = 0; e < 20; e++) drive(4'b0100, 4'b0001);
    check("d_err_cnt_sat", 32'(err_cnt), 32'd15);
    check("d_flags", 32'({err_timeout, err_spurious}), 32'h41);
    drive(4'b0, 4'b0);
    // reset mid-WAIT, req held through release
    do_reset();
    for (int e = 0; e < 3; e++) drive(4'b0001, 4'b0);
    rst_n = 1'b0;
    drive(4'b0001, 4'b0);
    check("e_reset_outputs", 32'({err_timeout, err_early, err_drop, err_spurious, err_any, err_cnt,
                                  first_err_valid, first_err_ch, pass_cnt}), 32'd0);
    check("e_ch0_idle", 32'(dut.g_ch[0].u_ch.state), 32'(S_IDLE));
    rst_n = 1'b1;
    drive(4'b0001, 4'b0);
    drive(4'b0001, 4'b0);
    drive(4'b0001, 4'b0001);
    drive(4'b0000, 4'b0001);
    drive(4'b0000, 4'b0000);
    check("e_pass_cnt", 32'(pass_cnt), PEN ? 32'd1 : 32'd0);
    check("e_err_any", 32'(err_any), 32'd0);
    // clr coincident with ch1 timeout; earlier ch3 spurious also cleared
    do_reset();
    drive(4'b0010, 4'b1000);
    for (int e = 1; e < 5; e++) drive(4'b0010, 4'b0);
    clr = 1'b1;
    drive(4'b0010, 4'b0);
    clr = 1'b0;
    check("f_timeout", 32'(err_timeout), 32'd0);
    check("f_spurious", 32'(err_spurious), 32'd0);
    check("f_err_cnt", 32'(err_cnt), 32'd0);
    check("f_first_valid", 32'(first_err_valid), 32'd0);
    check("f_ch1_err", 32'(dut.g_ch[1].u_ch.state), 32'(S_ERR));
    drive(4'b0010, 4'b0);
    check("f_err_cnt_after", 32'(err_cnt), 32'd0);
    drive(4'b0, 4'b0);
    // ack at MAX_LAT passes, ack with req drop passes, req+ack from IDLE is spurious
    do_reset();
    drive(4'b1011, 4'b0001);
    drive(4'b1010, 4'b0000);
    drive(4'b1000, 4'b0010);
    drive(4'b1000, 4'b0010);
    drive(4'b1000, 4'b0000);
    drive(4'b1000, 4'b1000);
    drive(4'b0000, 4'b1000);
    drive(4'b0000, 4'b0000);
    check("g_pass_cnt", 32'(pass_cnt), PEN ? 32'd2 : 32'd0);
    check("g_spurious", 32'(err_spurious), 32'h1);
    check("g_timeout", 32'(err_timeout), 32'd0);
    check("g_err_cnt", 32'(err_cnt), 32'd1);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
